controlador_banco_registros: RTL and testbench



---
 rtl/banco_registros_pkg.sv | 25 ++
 rtl/arbitro_rr_2.sv | 24 ++
 rtl/controlador_banco_registros.sv | 131 +++++++++++++
 tb/tb_controlador_banco_registros.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/banco_registros_pkg.sv
// -----------------------------------------------------------------------------
// banco_registros_pkg
// Shared types and constants for the register-bank write-port controller.
//   state_t      : controller FSM states (INIT_CLEAR, RUN)
//   REQ_ALU/MEM  : requester ids, also the encoding of last_grant and the
//                  bit positions in the arbiter valid/grant vectors
//   DEFAULT_*    : default data/address widths for the bank
//   ZERO_REG     : hardwired-zero register address, never written
// -----------------------------------------------------------------------------
package banco_registros_pkg;

    typedef enum logic {
        INIT_CLEAR = 1'b0,
        RUN        = 1'b1
    } state_t;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/arbitro_rr_2.sv
// -----------------------------------------------------------------------------
// arbitro_rr_2
// Combinational two-requester round-robin arbiter.
//   valid[1:0]  : request lines, bit REQ_ALU and bit REQ_MEM
//   last_grant  : requester that won the previous arbitration
//   grant[1:0]  : one-hot (or zero) grant
// A lone requester always wins; on contention the requester that did not
// win last time is granted.
// -----------------------------------------------------------------------------
module arbitro_rr_2
    import banco_registros_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant          = 2'b00;
        grant[REQ_ALU] = valid[REQ_ALU] && (!valid[REQ_MEM] || (last_grant == REQ_MEM));
        grant[REQ_MEM] = valid[REQ_MEM] && (!valid[REQ_ALU] || (last_grant == REQ_ALU));
    end

endmodule

// File: rtl/controlador_banco_registros.sv
// -----------------------------------------------------------------------------
// controlador_banco_registros
// Write-port controller for the register bank. After reset it clears every
// register to zero, then arbitrates the single write port between the ALU
// and load writeback requesters (valid/ready, round-robin).
//   clk, reset              : clock, synchronous active-high reset
//   alu_req_*               : ALU writeback request (valid/address/data/ready)
//   mem_req_*               : load writeback request (valid/address/data/ready)
//   write_address,
//   data_write, write_enable: registered bank write port
//   init_done               : clear sequence finished (sticky until reset)
//   last_grant              : winner of the most recent arbitration (0=ALU)
//   stall_count             : saturating count of cycles with a refused request
// -----------------------------------------------------------------------------
module controlador_banco_registros
    import banco_registros_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REGS        = 32,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_req_valid,
    input  logic [ADDR_WIDTH-1:0]      alu_req_address,
    input  logic [DATA_WIDTH-1:0]      alu_req_data,
    output logic                       alu_req_ready,
    input  logic                       mem_req_valid,
    input  logic [ADDR_WIDTH-1:0]      mem_req_address,
    input  logic [DATA_WIDTH-1:0]      mem_req_data,
    output logic                       mem_req_ready,
    output logic [ADDR_WIDTH-1:0]      write_address,
    output logic [DATA_WIDTH-1:0]      data_write,
    output logic                       write_enable,
    output logic                       init_done,
    output logic                       last_grant,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    // One extra bit so the counter can reach NUM_REGS, the "clear finished" mark.
    localparam int CNT_WIDTH = $clog2(NUM_REGS + 1);

    state_t                state;
    state_t                next_state;
    logic [CNT_WIDTH-1:0]  clear_count;
    logic                  clear_finished;
    logic [1:0]            grant;
    logic                  transfer;
    logic                  stalled;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;

    arbitro_rr_2 u_arbitro (
        .valid      ({mem_req_valid, alu_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state     = state;
        alu_req_ready  = 1'b0;
        mem_req_ready  = 1'b0;
        clear_finished = (clear_count == CNT_WIDTH'(NUM_REGS));
        case (state)
            INIT_CLEAR: if (clear_finished) next_state = RUN;
            RUN: begin
                alu_req_ready = grant[REQ_ALU];
                mem_req_ready = grant[REQ_MEM];
            end
            default: next_state = INIT_CLEAR;
        endcase
    end

    assign transfer    = alu_req_ready || mem_req_ready;
    assign sel_address = mem_req_ready ? mem_req_address : alu_req_address;
    assign sel_data    = mem_req_ready ? mem_req_data    : alu_req_data;
    assign stalled     = (state == RUN) &&
                         ((alu_req_valid && !alu_req_ready) ||
                          (mem_req_valid && !mem_req_ready));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= INIT_CLEAR;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_count   <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            data_write    <= '0;
            init_done     <= 1'b0;
            last_grant    <= REQ_MEM;   // ALU gets the first contested grant
            stall_count   <= '0;
        end else begin
            case (state)
                INIT_CLEAR: begin
                    if (!clear_finished) begin
                        write_enable  <= 1'b1;
                        write_address <= clear_count[ADDR_WIDTH-1:0];
                        data_write    <= '0;
                        clear_count   <= clear_count + CNT_WIDTH'(1);
                    end else begin
                        write_enable <= 1'b0;
                        init_done    <= 1'b1;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        // Address 0 is hardwired zero: accept, but never write.
                        write_enable  <= (sel_address != ADDR_WIDTH'(ZERO_REG));
                        write_address <= sel_address;
                        data_write    <= sel_data;
                        last_grant    <= mem_req_ready ? REQ_MEM : REQ_ALU;
                    end else begin
                        write_enable <= 1'b0;
                    end
                    if (stalled && (stall_count != '1))
                        stall_count <= stall_count + STALL_CNT_WIDTH'(1);
                end
                default: write_enable <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_banco_registros.sv
// -----------------------------------------------------------------------------
// tb_controlador_banco_registros
// Directed, table-driven bench for controlador_banco_registros.
// -----------------------------------------------------------------------------
module tb_controlador_banco_registros;

    logic        clk;
    logic        reset;
    logic        alu_req_valid;
    logic [4:0]  alu_req_address;
    logic [31:0] alu_req_data;
    logic        alu_req_ready;
    logic        mem_req_valid;
    logic [4:0]  mem_req_address;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;
    logic [4:0]  write_address;
    logic [31:0] data_write;
    logic        write_enable;
    logic        init_done;
    logic        last_grant;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    controlador_banco_registros dut (
        .clk             (clk),
        .reset           (reset),
        .alu_req_valid   (alu_req_valid),
        .alu_req_address (alu_req_address),
        .alu_req_data    (alu_req_data),
        .alu_req_ready   (alu_req_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_address (mem_req_address),
        .mem_req_data    (mem_req_data),
        .mem_req_ready   (mem_req_ready),
        .write_address   (write_address),
        .data_write      (data_write),
        .write_enable    (write_enable),
        .init_done       (init_done),
        .last_grant      (last_grant),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        mem_v;
        logic [4:0]  mem_a;
        logic [31:0] mem_d;
        logic        exp_alu_r;
        logic        exp_mem_r;
        logic        exp_we;
        logic        chk_wd;     // compare address/data after the edge
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        alu_req_valid   = av;
        alu_req_address = aa;
        alu_req_data    = ad;
        mem_req_valid   = mv;
        mem_req_address = ma;
        mem_req_data    = md;
    endtask

    // Full clear sequence from reset release; requests are held high to show
    // they are ignored and not counted as stalls.
    task automatic run_clear(input string tag);
        drive(1'b1, 5'd7, 32'h1234, 1'b1, 5'd8, 32'h5678);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            #1;
            check($sformatf("%s alu_ready_%0d", tag, k), {31'd0, alu_req_ready}, 32'd0);
            check($sformatf("%s mem_ready_%0d", tag, k), {31'd0, mem_req_ready}, 32'd0);
            step();
            check($sformatf("%s we_%0d", tag, k),   {31'd0, write_enable}, 32'd1);
            check($sformatf("%s addr_%0d", tag, k), {27'd0, write_address}, 32'(k - 1));
            check($sformatf("%s data_%0d", tag, k), data_write, 32'd0);
            check($sformatf("%s init_%0d", tag, k), {31'd0, init_done}, 32'd0);
        end
        step();
        check({tag, " we_end"},    {31'd0, write_enable}, 32'd0);
        check({tag, " init_done"}, {31'd0, init_done}, 32'd1);
        check({tag, " stall"},     {16'd0, stall_count}, 32'd0);
        check({tag, " last"},      {31'd0, last_grant}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        //             alu_v alu_a  alu_d         mem_v mem_a  mem_d         aR mR we chk addr   data          last
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1, 0, 1, 1, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       0, 0, 0, 1, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd3,  32'h11,      1'b1, 5'd4,  32'h22,      0, 1, 1, 1, 5'd4,  32'h22,       1'b1};
        vecs[3]  = '{1'b1, 5'd3,  32'h11,      1'b1, 5'd4,  32'h22,      1, 0, 1, 1, 5'd3,  32'h11,       1'b0};
        vecs[4]  = '{1'b1, 5'd3,  32'h11,      1'b1, 5'd4,  32'h22,      0, 1, 1, 1, 5'd4,  32'h22,       1'b1};
        vecs[5]  = '{1'b1, 5'd3,  32'h11,      1'b1, 5'd4,  32'h22,      1, 0, 1, 1, 5'd3,  32'h11,       1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd0,  32'hFFFFFFFF, 0, 1, 0, 0, 5'd0,  32'h0,        1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd7,  32'h77,      0, 1, 1, 1, 5'd7,  32'h77,       1'b1};
        vecs[8]  = '{1'b1, 5'd9,  32'h99,      1'b0, 5'd0,  32'h0,       1, 0, 1, 1, 5'd9,  32'h99,       1'b0};
        vecs[9]  = '{1'b1, 5'd12, 32'hA,       1'b1, 5'd12, 32'hB,       0, 1, 1, 1, 5'd12, 32'hB,        1'b1};
        vecs[10] = '{1'b1, 5'd12, 32'hA,       1'b1, 5'd12, 32'hB,       1, 0, 1, 1, 5'd12, 32'hA,        1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       0, 0, 0, 1, 5'd12, 32'hA,        1'b0};

        reset = 1'b1;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        step();
        step();
        check("rst we",        {31'd0, write_enable}, 32'd0);
        check("rst addr",      {27'd0, write_address}, 32'd0);
        check("rst data",      data_write, 32'd0);
        check("rst init_done", {31'd0, init_done}, 32'd0);
        check("rst last",      {31'd0, last_grant}, 32'd1);
        check("rst stall",     {16'd0, stall_count}, 32'd0);
        check("rst alu_ready", {31'd0, alu_req_ready}, 32'd0);
        check("rst mem_ready", {31'd0, mem_req_ready}, 32'd0);

        run_clear("init");

        // Table: 6 of these cycles (vectors 2-5, 9, 10) carry a refused request.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d,
                  vecs[i].mem_v, vecs[i].mem_a, vecs[i].mem_d);
            #1;
            check($sformatf("v%0d alu_ready", i), {31'd0, alu_req_ready}, {31'd0, vecs[i].exp_alu_r});
            check($sformatf("v%0d mem_ready", i), {31'd0, mem_req_ready}, {31'd0, vecs[i].exp_mem_r});
            step();
            check($sformatf("v%0d we", i),   {31'd0, write_enable}, {31'd0, vecs[i].exp_we});
            check($sformatf("v%0d last", i), {31'd0, last_grant},   {31'd0, vecs[i].exp_last});
            if (vecs[i].chk_wd) begin
                check($sformatf("v%0d addr", i), {27'd0, write_address}, {27'd0, vecs[i].exp_addr});
                check($sformatf("v%0d data", i), data_write, vecs[i].exp_data);
            end
        end
        check("stall after table", {16'd0, stall_count}, 32'd6);

        // Saturation: both valid held; one refused request per cycle.
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        for (int n = 0; n < 65528; n++) step();
        check("stall near max", {16'd0, stall_count}, 32'hFFFE);
        for (int n = 0; n < 13; n++) step();
        check("stall saturated", {16'd0, stall_count}, 32'hFFFF);
        check("sat we", {31'd0, write_enable}, 32'd1);

        // Reset in the middle of a clear: restart at address 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 11; k++) step();
        check("mid addr10",  {27'd0, write_address}, 32'd10);
        check("mid we",      {31'd0, write_enable}, 32'd1);
        reset = 1'b1;
        step();
        check("mid rst we",    {31'd0, write_enable}, 32'd0);
        check("mid rst addr",  {27'd0, write_address}, 32'd0);
        check("mid rst init",  {31'd0, init_done}, 32'd0);
        check("mid rst stall", {16'd0, stall_count}, 32'd0);
        run_clear("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
